sensor_event_tx: RTL
====================

SENSOR_EVENT_TX -- requirements
Module: sensor_event_tx

Interface
REQ-001 Parameter DEB_CYCLES, default 400000, debounce stability window in clk cycles (10 ms at 40 MHz).
REQ-002 Parameter CNT_W, default 19, debounce counter width; SHALL satisfy 2**CNT_W > DEB_CYCLES.
REQ-003 clk  input  1  single system clock (40 MHz domain).
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 entry_sensor  input  1  raw, asynchronous entry-gate sensor level.
REQ-006 exit_sensor  input  1  raw, asynchronous exit-gate sensor level.
REQ-007 switch  input  2  slot index chosen by the driver, sampled at event latch.
REQ-008 occupied  input  4  current slot occupancy from the parking FSM; bit n=1 means slot n is taken.
REQ-009 evt_ready  input  1  FSM accepts the event this cycle.
REQ-010 evt_valid  output  1  event payload valid.
REQ-011 evt_type  output  1  0=entry, 1=exit.
REQ-012 evt_slot  output  2  slot index of the event.
REQ-013 evt_reject  output  1  event is illegal: entry to an occupied slot or exit from an empty slot.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Each raw sensor SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles, and any bounce restarts the count.
REQ-016 A 0->1 debounced transition SHALL set a pending flag for that sensor, and the flag SHALL clear when its event is latched.
REQ-017 FSM states: IDLE, LATCH, SEND, HOLDOFF.
REQ-018 IDLE->LATCH when any pending flag is set; with both flags set, entry is served first and the exit flag stays pending.
REQ-019 In LATCH (1 cycle), evt_type, evt_slot=switch and evt_reject SHALL be registered: entry rejects if occupied[switch]=1, exit rejects if occupied[switch]=0; then ->SEND.
REQ-020 In SEND, evt_valid=1 and evt_type/evt_slot/evt_reject SHALL hold stable until the cycle evt_valid&&evt_ready; that handshake cycle ->HOLDOFF.
REQ-021 In HOLDOFF, the FSM SHALL wait until the debounced level of the served sensor is 0, then ->IDLE; a pending flag of the other sensor survives HOLDOFF.
REQ-022 Latency: a debounced rising edge in IDLE SHALL give evt_valid=1 exactly 2 cycles later.
REQ-023 Occupancy changes after LATCH SHALL NOT alter the registered payload.
REQ-024 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-025 On reset: state=IDLE, synchronizers, debounced levels, debounce counters and pending flags=0, evt_valid=0, evt_type=0, evt_slot=0, evt_reject=0, busy=0.
REQ-026 Reset asserted during SEND SHALL drop the in-flight event with no replay after release.

Configuration
REQ-027 With SENSOR_EVENT_COUNT_EN defined, outputs entry_cnt[7:0] and exit_cnt[7:0] SHALL exist and increment, saturating at 255, on each accepted non-rejected event of their type; reset clears them.
REQ-028 Without SENSOR_EVENT_COUNT_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-029 Package parking_pkg SHALL hold the evt_type encoding constants (EVT_ENTRY=0, EVT_EXIT=1), the FSM state encoding, and default DEB_CYCLES/CNT_W.
REQ-030 Sub-module sensor_debounce (synchronizer plus debouncer, parameterised by DEB_CYCLES/CNT_W) SHALL be instantiated once per sensor.

Verification (DEB_CYCLES=4)
REQ-031 Entry sensor high 10 cycles, switch=2, occupied=4'b0000, evt_ready=1 -> one evt_valid pulse, type=0, slot=2, reject=0.
REQ-032 Entry sensor toggling every 2 cycles for 20 cycles -> no event; then stable high 6 cycles -> exactly one event.
REQ-033 Exit, switch=1, occupied=4'b0000 -> type=1, slot=1, reject=1; with SENSOR_EVENT_COUNT_EN, exit_cnt stays 0.
REQ-034 Both sensors rise in the same cycle, evt_ready held 0 for 5 cycles -> entry payload held stable for 5 cycles, accepted, then the exit event follows after the entry sensor falls.
REQ-035 Reset pulsed during SEND -> evt_valid=0 next cycle, and no event after release until a new rising edge.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking-gate sensor event path.
package parking_pkg;

   localparam int unsigned DEF_DEB_CYCLES = 400000;
   localparam int unsigned DEF_CNT_W      = 19;

   localparam logic EVT_ENTRY = 1'b0;
   localparam logic EVT_EXIT  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SEND,
      ST_HOLDOFF
   } evt_state_t;

   // Entry into a taken slot or exit from a free slot is illegal.
   function automatic logic evt_is_reject(input logic typ, input logic slot_taken);
      return (typ == EVT_ENTRY) ? slot_taken : !slot_taken;
   endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability-window debouncer for one raw sensor.
module sensor_debounce
   import parking_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned CNT_W      = DEF_CNT_W
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;
   logic             w_diff;
   logic             w_done;

   assign w_diff = r_sync[1] ^ r_level;
   assign w_done = w_diff && (r_cnt == LP_LAST);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync  <= '0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         // Any sample matching the current level restarts the window.
         if (!w_diff || w_done)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + LP_ONE;
         if (w_done)
            r_level <= r_sync[1];
      end
   end

   assign o_level = r_level;
   assign o_rise  = w_done && r_sync[1];

endmodule

// File: rtl/sensor_event_tx.sv
// Turns debounced entry/exit gate sensors into a valid/ready event stream for the parking FSM.
// Optional per-type accepted-event counters are built when SENSOR_EVENT_COUNT_EN is defined.
module sensor_event_tx
   import parking_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned CNT_W      = DEF_CNT_W
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   input  logic [1:0] switch,
   input  logic [3:0] occupied,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic       evt_type,
   output logic [1:0] evt_slot,
   output logic       evt_reject,
   output logic       busy
`ifdef SENSOR_EVENT_COUNT_EN
   ,
   output logic [7:0] entry_cnt,
   output logic [7:0] exit_cnt
`endif
);

   evt_state_t r_state;
   evt_state_t w_state_nxt;

   logic       w_ent_level;
   logic       w_ent_rise;
   logic       w_ext_level;
   logic       w_ext_rise;
   logic       r_pend_ent;
   logic       r_pend_ext;
   logic       r_serve;
   logic       r_type;
   logic [1:0] r_slot;
   logic       r_reject;
   logic       w_take;
   logic       w_latch;
   logic       w_accept;
   logic       w_take_type;
   logic       w_served_level;

   sensor_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_deb_entry (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_raw   (entry_sensor),
      .o_level (w_ent_level),
      .o_rise  (w_ent_rise)
   );

   sensor_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_deb_exit (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_raw   (exit_sensor),
      .o_level (w_ext_level),
      .o_rise  (w_ext_rise)
   );

   // Entry wins when both are pending; the exit flag simply stays set.
   assign w_take_type    = r_pend_ent ? EVT_ENTRY : EVT_EXIT;
   assign w_served_level = (r_serve == EVT_ENTRY) ? w_ent_level : w_ext_level;

   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_latch     = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_pend_ent || r_pend_ext) begin
               w_take      = 1'b1;
               w_state_nxt = ST_LATCH;
            end
         end
         ST_LATCH: begin
            w_latch     = 1'b1;
            w_state_nxt = ST_SEND;
         end
         ST_SEND: begin
            if (evt_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_HOLDOFF;
            end
         end
         ST_HOLDOFF: begin
            if (!w_served_level)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_pend_ent <= 1'b0;
         r_pend_ext <= 1'b0;
         r_serve    <= EVT_ENTRY;
         r_type     <= EVT_ENTRY;
         r_slot     <= '0;
         r_reject   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ent_rise)
            r_pend_ent <= 1'b1;
         else if (w_take && (w_take_type == EVT_ENTRY))
            r_pend_ent <= 1'b0;
         if (w_ext_rise)
            r_pend_ext <= 1'b1;
         else if (w_take && (w_take_type == EVT_EXIT))
            r_pend_ext <= 1'b0;
         if (w_take)
            r_serve <= w_take_type;
         if (w_latch) begin
            r_type   <= r_serve;
            r_slot   <= switch;
            r_reject <= evt_is_reject(r_serve, occupied[switch]);
         end
      end
   end

   assign evt_valid  = (r_state == ST_SEND);
   assign evt_type   = r_type;
   assign evt_slot   = r_slot;
   assign evt_reject = r_reject;
   assign busy       = (r_state != ST_IDLE);

`ifdef SENSOR_EVENT_COUNT_EN
   logic [7:0] r_entry_cnt;
   logic [7:0] r_exit_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_entry_cnt <= '0;
         r_exit_cnt  <= '0;
      end else if (w_accept && !r_reject) begin
         if (r_type == EVT_ENTRY) begin
            if (r_entry_cnt != 8'hFF)
               r_entry_cnt <= r_entry_cnt + 8'd1;
         end else begin
            if (r_exit_cnt != 8'hFF)
               r_exit_cnt <= r_exit_cnt + 8'd1;
         end
      end
   end

   assign entry_cnt = r_entry_cnt;
   assign exit_cnt  = r_exit_cnt;
`endif

endmodule
